// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory arbitration controller: opcodes, FSM states
// and the cache-line fill-count derivation.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_RSVD  = 2'b10,
    OP_WRITE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_ARB,
    ST_WFILL,
    ST_HOSTWR,
    ST_HOSTRD,
    ST_RDRAIN
  } state_e;

  // Number of channel words that make up one host cache line.
  function automatic int unsigned fill_count_f(input int unsigned cl_size_width,
                                               input int unsigned word_size);
    return cl_size_width / word_size;
  endfunction

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Channel-side and host-side bus bundle of mem_arb_ctrl.
interface mem_arb_ctrl_if #(
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned CL_SIZE_WIDTH = 512,
  parameter int unsigned ADDR_BITCOUNT = 64,
  parameter int unsigned NUM_CH        = 4
);

  logic                                host_init;
  logic                                host_rd_ready;
  logic                                host_wr_ready;
  logic [NUM_CH-1:0][1:0]              ch_op;
  logic [NUM_CH-1:0][ADDR_BITCOUNT-1:0] ch_addr;
  logic [ADDR_BITCOUNT-1:0]            address_offset;
  logic [NUM_CH-1:0][WORD_SIZE-1:0]    ch_wdata;
  logic [CL_SIZE_WIDTH-1:0]            host_data_bus_read_in;
  logic [CL_SIZE_WIDTH-1:0]            host_data_bus_write_out;
  logic [ADDR_BITCOUNT-1:0]            host_addr;
  logic                                host_re;
  logic                                host_we;
  logic [NUM_CH-1:0]                   ch_grant;
  logic [WORD_SIZE-1:0]                ch_rdata;
  logic [NUM_CH-1:0]                   ch_wr_accept;
  logic [NUM_CH-1:0]                   ch_rd_valid;
  logic [NUM_CH-1:0]                   ch_tx_done;
  logic                                ready;

  // Controller side
  modport slave (
    input  host_init, host_rd_ready, host_wr_ready, ch_op, ch_addr,
           address_offset, ch_wdata, host_data_bus_read_in,
    output host_data_bus_write_out, host_addr, host_re, host_we, ch_grant,
           ch_rdata, ch_wr_accept, ch_rd_valid, ch_tx_done, ready
  );

  // Environment side (channels + host)
  modport master (
    output host_init, host_rd_ready, host_wr_ready, ch_op, ch_addr,
           address_offset, ch_wdata, host_data_bus_read_in,
    input  host_data_bus_write_out, host_addr, host_re, host_we, ch_grant,
           ch_rdata, ch_wr_accept, ch_rd_valid, ch_tx_done, ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester strictly after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  output logic [NUM_CH-1:0]         grant
);

  localparam int unsigned CW = $clog2(NUM_CH);

  logic [CW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = CW'((32'(last_grant) + i) % NUM_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbitrates NUM_CH word-wide channels onto a cache-line host port,
// assembling write lines and draining read lines one word per cycle.
module mem_arb_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned CL_SIZE_WIDTH = 512,
  parameter int unsigned ADDR_BITCOUNT = 64,
  parameter int unsigned NUM_CH        = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arb_ctrl_if.slave  bus
);

  localparam int unsigned FILL_COUNT = fill_count_f(CL_SIZE_WIDTH, WORD_SIZE);
  localparam int unsigned FW         = $clog2(FILL_COUNT);
  localparam int unsigned CW         = $clog2(NUM_CH);

  state_e                               state_q, state_d;
  logic [FW-1:0]                        fill_q, fill_d;
  logic [FILL_COUNT-1:0][WORD_SIZE-1:0] line_q, line_d;
  logic [ADDR_BITCOUNT-1:0]             addr_q, addr_d;
  logic [CW-1:0]                        last_q, last_d;
  logic [CW-1:0]                        gidx_q, gidx_d;
  logic [NUM_CH-1:0]                    grant_q, grant_d;
  logic [NUM_CH-1:0]                    wr_acc_q, wr_acc_d;
  logic [NUM_CH-1:0]                    rd_val_q, rd_val_d;
  logic [WORD_SIZE-1:0]                 rdata_q, rdata_d;
  logic                                 re_q, re_d;
  logic                                 we_q, we_d;
  logic                                 ready_q, ready_d;
  logic [NUM_CH-1:0]                    tx_done_c;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] arb_gnt;
  logic [CW-1:0]     arb_idx;

  // Reserved opcode 10 is not a request.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      req[i] = (bus.ch_op[i] == OP_READ) || (bus.ch_op[i] == OP_WRITE);
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .req        (req),
    .last_grant (last_q),
    .grant      (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) arb_idx = CW'(i);
    end
  end

  // Next state, datapath and next registered outputs.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    line_d    = line_q;
    addr_d    = addr_q;
    last_d    = last_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    tx_done_c = '0;

    case (state_q)
      ST_STARTUP: begin
        if (bus.host_init) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (|req) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          last_d  = arb_idx;
          addr_d  = bus.ch_addr[arb_idx] + bus.address_offset;
          fill_d  = '0;
          state_d = (bus.ch_op[arb_idx] == OP_WRITE) ? ST_WFILL : ST_HOSTRD;
        end
      end
      ST_WFILL: begin
        line_d[fill_q] = bus.ch_wdata[gidx_q];
        fill_d         = fill_q + 1'b1;
        if (fill_q == FW'(FILL_COUNT - 1)) state_d = ST_HOSTWR;
      end
      ST_HOSTWR: begin
        if (bus.host_wr_ready) begin
          tx_done_c = grant_q;
          grant_d   = '0;
          state_d   = ST_ARB;
        end
      end
      ST_HOSTRD: begin
        if (bus.host_rd_ready) begin
          line_d  = bus.host_data_bus_read_in;
          fill_d  = '0;
          state_d = ST_RDRAIN;
        end
      end
      ST_RDRAIN: begin
        fill_d = fill_q + 1'b1;
        if (fill_q == FW'(FILL_COUNT - 1)) begin
          tx_done_c = grant_q;
          grant_d   = '0;
          state_d   = ST_ARB;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    ready_d  = (state_d != ST_STARTUP);
    wr_acc_d = (state_d == ST_WFILL)  ? grant_d : '0;
    rd_val_d = (state_d == ST_RDRAIN) ? grant_d : '0;
    re_d     = (state_d == ST_HOSTRD);
    we_d     = (state_d == ST_HOSTWR);
    rdata_d  = line_d[fill_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_STARTUP;
      fill_q   <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      last_q   <= CW'(NUM_CH - 1);
      gidx_q   <= '0;
      grant_q  <= '0;
      wr_acc_q <= '0;
      rd_val_q <= '0;
      rdata_q  <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      line_q   <= line_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      wr_acc_q <= wr_acc_d;
      rd_val_q <= rd_val_d;
      rdata_q  <= rdata_d;
      re_q     <= re_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.host_data_bus_write_out = line_q;
  assign bus.host_addr               = addr_q;
  assign bus.host_re                 = re_q;
  assign bus.host_we                 = we_q;
  assign bus.ch_grant                = grant_q;
  assign bus.ch_rdata                = rdata_q;
  assign bus.ch_wr_accept            = wr_acc_q;
  assign bus.ch_rd_valid             = rd_val_q;
  assign bus.ch_tx_done              = tx_done_c;
  assign bus.ready                   = ready_q;

endmodule
